multi_bcd_display: RTL and testbench
====================================

Name: multi_bcd_display

Overview:
- Parametrised successor to the fixed per-value bcd + ssd display pairs; drives the board seven-segment bank.
- Accepts a bundle of CHANNELS unsigned values through a valid/ready handshake.
- Converts each value to DIGITS decimal digits with a sequential shift-add-3 (double-dabble) engine.
- Commits all channels to the segment outputs atomically; flags values that do not fit in DIGITS digits.

Parameters:
CHANNELS, 2, number of displayed values (1..8)
IN_WIDTH, 6, bits per value (1..16)
DIGITS, 2, decimal digits per channel (1..5)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data bundle valid
in_ready  output  1  block can accept a bundle (high only in IDLE)
in_data  input  CHANNELS*IN_WIDTH  channel c at bits [c*IN_WIDTH +: IN_WIDTH]
busy  output  1  conversion in progress (not IDLE)
overflow  output  CHANNELS  per-channel value >= 10^DIGITS, committed with hex
hex  output  CHANNELS*DIGITS*7  channel c, digit d (d=0 ones) at [(c*DIGITS+d)*7 +: 7]

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Segment code: 7 bits {g,f,e,d,c,b,a}, active-low.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - dash=0111111, blank=1111111
- Reset values: state IDLE, in_ready=1, busy=0, overflow=0, every hex digit = "0" (1000000). Internal captured data and shadow registers are cleared.
- Reset mid-operation: conversion aborted, captured bundle discarded, outputs return to reset values on that edge.
- States:
  - IDLE: in_ready=1. in_valid=1 captures the whole in_data bundle, sets channel index=0 and clears the BCD accumulator; next state SHIFT.
  - SHIFT: IN_WIDTH cycles per channel. Each cycle adds 3 to every BCD digit >=5, then shifts {BCD, value} left by 1. Next state STORE after the IN_WIDTH-th cycle.
  - STORE: 1 cycle. Writes encoded digits and the overflow flag of the current channel into shadow registers. If index < CHANNELS-1: index+1, reload, go to SHIFT. Otherwise go to COMMIT.
  - COMMIT: 1 cycle. Copies shadow registers to hex/overflow in one edge, then returns to IDLE.
- Overflow: captured value >= 10^DIGITS (constant computed at elaboration).
  - The channel shows dash on all its digits and its overflow bit is 1.
  - The BCD result of that channel is ignored.
- Latency: hex/overflow update on the edge CHANNELS*(IN_WIDTH+1)+1 cycles after the capture edge. With defaults: 15 cycles.
- Throughput: with in_valid held high, one capture every CHANNELS*(IN_WIDTH+1)+2 cycles (16 with defaults).
- Busy behaviour: in_valid during busy is ignored (no queueing). Changes of in_data after capture do not affect the result.
- Between commits, hex and overflow are stable. Mixed old/new channel sets never appear.
- Value 0 displays "0" in the ones digit.

Optional Feature:
- Macro: MULTI_BCD_DISPLAY_LEADING_ZERO_BLANK_EN
- Defined: in non-overflow channels, zero digits above the most significant non-zero digit are blank (1111111). The ones digit is never blanked.
- Undefined: leading zeros are shown as "0". Overflow dashes are unaffected either way.

Test Plan:
- Reset, no input (defaults) -> in_ready=1, busy=0, overflow=00, hex=28'h all digits 1000000.
- Defaults, capture ch0=42, ch1=7:
  - busy=1 for 15 cycles; hex unchanged until the 15th edge.
  - Then hex[6:0]=0100100, [13:7]=0011001, [20:14]=1111000, [27:21]=1000000, overflow=00.
  - in_ready=1 the next cycle.
- DIGITS=1, IN_WIDTH=4, CHANNELS=2, capture ch0=12, ch1=9 -> hex[6:0]=0111111, hex[13:7]=0010000, overflow=01.
- Defaults, capture 63/0, hold in_valid=1 and switch in_data to 5/5 during busy:
  - First commit shows 63/0.
  - Second capture occurs 16 cycles after the first, and 15 cycles later shows 05/05.
- Defaults, assert rst for 1 cycle at cycle 8 of a conversion -> outputs at reset values after that edge; no later commit of the aborted bundle.
- With the MULTI_BCD_DISPLAY_LEADING_ZERO_BLANK_EN macro defined, capture ch0=7, ch1=0 -> hex[13:7]=1111111, hex[27:21]=1111111, ones digits 1111000 and 1000000.

Source files
------------

// File: rtl/multi_bcd_display.sv
// Multi-channel binary-to-BCD seven-segment driver: sequential double-dabble per channel, atomic commit.
// Optional build macro: MULTI_BCD_DISPLAY_LEADING_ZERO_BLANK_EN (blank leading zero digits).
module multi_bcd_display #(
  parameter int CHANNELS = 2,
  parameter int IN_WIDTH = 6,
  parameter int DIGITS   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_data,
  output logic                         busy,
  output logic [CHANNELS-1:0]          overflow,
  output logic [CHANNELS*DIGITS*7-1:0] hex
);

  // state  | meaning
  // IDLE   | waiting for a bundle, in_ready high
  // SHIFT  | shift-add-3 on the current channel, IN_WIDTH cycles
  // STORE  | encode current channel into shadow registers, advance
  // COMMIT | copy shadow registers to outputs in one edge
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_STORE  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  localparam int BW    = 4 * DIGITS;
  localparam int HEX_W = 7 * DIGITS;
  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam int unsigned LIMIT = pow10(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IN_WIDTH - 1);

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  logic [1:0]                   r_state;
  logic [CHANNELS*IN_WIDTH-1:0] r_data;
  logic [IN_WIDTH-1:0]          r_shift;
  logic [BW-1:0]                r_bcd;
  logic                         r_cout;
  logic [CNT_W-1:0]             r_cnt;
  logic [IDX_W-1:0]             r_idx;
  logic [CHANNELS*HEX_W-1:0]    r_hex_sh;
  logic [CHANNELS-1:0]          r_ovf_sh;
  logic [CHANNELS*HEX_W-1:0]    r_hex;
  logic [CHANNELS-1:0]          r_ovf;

  logic [BW-1:0]                w_bcd_adj;
  logic [CHANNELS*IN_WIDTH-1:0] w_data_nxt;
  logic [IN_WIDTH-1:0]          w_cur_val;
  logic                         w_ovf;
  logic [HEX_W-1:0]             w_chan_hex;
`ifdef MULTI_BCD_DISPLAY_LEADING_ZERO_BLANK_EN
  logic                         w_lead;
`endif

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign hex        = r_hex;
  assign overflow   = r_ovf;
  assign w_data_nxt = r_data >> IN_WIDTH;
  assign w_cur_val  = r_data[IN_WIDTH-1:0];

  // A bit leaving the top digit is equivalent to the range compare; both feed the flag.
  assign w_ovf = (32'(w_cur_val) >= LIMIT) | r_cout;

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_chan_hex = '0;
`ifdef MULTI_BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    w_lead = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (w_lead && (d != 0) && (r_bcd[d*4 +: 4] == 4'd0)) begin
        w_chan_hex[d*7 +: 7] = SEG_BLANK;
      end else begin
        w_lead = 1'b0;
        w_chan_hex[d*7 +: 7] = seg7(r_bcd[d*4 +: 4]);
      end
    end
`else
    for (int d = 0; d < DIGITS; d++) begin
      w_chan_hex[d*7 +: 7] = seg7(r_bcd[d*4 +: 4]);
    end
`endif
    if (w_ovf) w_chan_hex = {DIGITS{SEG_DASH}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_data   <= '0;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_hex_sh <= {(CHANNELS*DIGITS){SEG_ZERO}};
      r_ovf_sh <= '0;
      r_hex    <= {(CHANNELS*DIGITS){SEG_ZERO}};
      r_ovf    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data  <= in_data;
            r_shift <= in_data[IN_WIDTH-1:0];
            r_bcd   <= '0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= CNT_LOAD;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd   <= {w_bcd_adj[BW-2:0], r_shift[IN_WIDTH-1]};
          r_cout  <= r_cout | w_bcd_adj[BW-1];
          r_shift <= r_shift << 1;
          if (r_cnt == '0) r_state <= S_STORE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_STORE: begin
          r_hex_sh[r_idx*HEX_W +: HEX_W] <= w_chan_hex;
          r_ovf_sh[r_idx]                <= w_ovf;
          if (int'(r_idx) < CHANNELS - 1) begin
            r_idx   <= r_idx + 1'b1;
            r_data  <= w_data_nxt;
            r_shift <= w_data_nxt[IN_WIDTH-1:0];
            r_bcd   <= '0;
            r_cout  <= 1'b0;
            r_cnt   <= CNT_LOAD;
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_hex   <= r_hex_sh;
          r_ovf   <= r_ovf_sh;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_bcd_display.sv
// Directed bench for multi_bcd_display: default instance plus a DIGITS=1/IN_WIDTH=4 instance.
module tb_multi_bcd_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, busy;
  logic [11:0] in_data;
  logic [1:0]  overflow;
  logic [27:0] hex;

  logic        in_valid2, in_ready2, busy2;
  logic [7:0]  in_data2;
  logic [1:0]  overflow2;
  logic [13:0] hex2;

  multi_bcd_display dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .overflow(overflow), .hex(hex)
  );

  multi_bcd_display #(.CHANNELS(2), .IN_WIDTH(4), .DIGITS(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .busy(busy2), .overflow(overflow2), .hex(hex2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int v0; int v1; int d0o; int d0t; int d1o; int d1t;
  } vec_t;

  typedef struct {
    int v0; int v1; int d0; int d1; logic [1:0] ovf;
  } vec2_t;

  vec_t  tab[7];
  vec2_t tab2[4];
  logic [27:0] reset_hex;
  logic [13:0] reset_hex2;

  // digit codes: 0..9, 10 = dash, 11 = blank
  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input int d0o, input int d0t, input int d1o, input int d1t);
    int t0, t1;
    t0 = d0t;
    t1 = d1t;
`ifdef MULTI_BCD_DISPLAY_LEADING_ZERO_BLANK_EN
    if (t0 == 0) t0 = 11;
    if (t1 == 0) t1 = 11;
`endif
    return {seg(t1), seg(d1o), seg(t0), seg(d0o)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle2();
    int n;
    n = 0;
    while (busy2 && n < 60) begin tick(); n++; end
    chk("idle2_timeout", {31'd0, busy2}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit stable;
    reset_hex  = {4{7'b1000000}};
    reset_hex2 = {2{7'b1000000}};
    tab[0] = '{10, 19, 0, 1, 9, 1};
    tab[1] = '{50, 35, 0, 5, 5, 3};
    tab[2] = '{ 9, 59, 9, 0, 9, 5};
    tab[3] = '{ 7,  0, 7, 0, 0, 0};
    tab[4] = '{63, 63, 3, 6, 3, 6};
    tab[5] = '{ 1, 40, 1, 0, 0, 4};
    tab[6] = '{ 0,  0, 0, 0, 0, 0};
    tab2[0] = '{12,  9, 10,  9, 2'b01};
    tab2[1] = '{15, 10, 10, 10, 2'b11};
    tab2[2] = '{ 0,  5,  0,  5, 2'b00};
    tab2[3] = '{ 9, 10,  9, 10, 2'b10};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
    ticks(2);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overflow", {30'd0, overflow}, 32'd0);
    chk("rst_hex", {4'd0, hex}, {4'd0, reset_hex});
    chk("rst2_in_ready", {31'd0, in_ready2}, 32'd1);
    chk("rst2_hex", {18'd0, hex2}, {18'd0, reset_hex2});

    // latency: commit exactly 15 edges after capture, input changes after capture ignored
    in_data = {6'd7, 6'd42}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_data = {6'd63, 6'd63};
    chk("lat_busy_after_capture", {31'd0, busy}, 32'd1);
    chk("lat_ready_after_capture", {31'd0, in_ready}, 32'd0);
    stable = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (hex !== reset_hex || busy !== 1'b1) stable = 1'b0;
    end
    chk("lat_hold_before_commit", {31'd0, stable}, 32'd1);
    tick();
    chk("lat_hex_42_7", {4'd0, hex}, {4'd0, exp_hex(2, 4, 7, 0)});
    chk("lat_ovf", {30'd0, overflow}, 32'd0);
    chk("lat_ready_after_commit", {31'd0, in_ready}, 32'd1);

    foreach (tab[k]) begin
      in_data = {6'(tab[k].v1), 6'(tab[k].v0)}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_idle();
      chk($sformatf("vec%0d_hex", k), {4'd0, hex},
          {4'd0, exp_hex(tab[k].d0o, tab[k].d0t, tab[k].d1o, tab[k].d1t)});
      chk($sformatf("vec%0d_ovf", k), {30'd0, overflow}, 32'd0);
    end

    // back-to-back with in_valid held: 63/0 then 5/5, captures 16 apart
    in_data = {6'd0, 6'd63}; in_valid = 1'b1;
    tick();
    in_data = {6'd5, 6'd5};
    ticks(14);
    tick();
    chk("b2b_first_hex", {4'd0, hex}, {4'd0, exp_hex(3, 6, 0, 0)});
    chk("b2b_ready_at_15", {31'd0, in_ready}, 32'd1);
    tick();
    chk("b2b_second_capture", {31'd0, busy}, 32'd1);
    ticks(14);
    chk("b2b_hold_before_second", {4'd0, hex}, {4'd0, exp_hex(3, 6, 0, 0)});
    tick();
    in_valid = 1'b0;
    chk("b2b_second_hex", {4'd0, hex}, {4'd0, exp_hex(5, 0, 5, 0)});

    // reset on cycle 8 of a conversion aborts it
    in_data = {6'd7, 6'd42}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ticks(7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_hex", {4'd0, hex}, {4'd0, reset_hex});
    chk("abort_ovf", {30'd0, overflow}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_ready", {31'd0, in_ready}, 32'd1);
    ticks(25);
    chk("abort_no_late_commit", {4'd0, hex}, {4'd0, reset_hex});

    // single-digit instance: overflow dashes and flags
    foreach (tab2[k]) begin
      in_data2 = {4'(tab2[k].v1), 4'(tab2[k].v0)}; in_valid2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      chk($sformatf("d1_vec%0d_busy", k), {31'd0, busy2}, 32'd1);
      wait_idle2();
      chk($sformatf("d1_vec%0d_hex", k), {18'd0, hex2},
          {18'd0, seg(tab2[k].d1), seg(tab2[k].d0)});
      chk($sformatf("d1_vec%0d_ovf", k), {30'd0, overflow2}, {30'd0, tab2[k].ovf});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
